// File: rtl/llr_pair_feeder.sv
// Buffers one N-point block of channel LLRs, converts each to Q8.4 with saturation and issues
// (llr[i], llr[i+N/2]) pairs. Define LLR_ROUND_EN to round half-up instead of flooring.
module llr_pair_feeder #(
  parameter int unsigned N       = 8,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned IN_FRAC = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_llr,
  output logic                     pair_valid,
  input  logic                     pair_ready,
  output logic [11:0]              llr_a,
  output logic [11:0]              llr_b,
  output logic [$clog2(N)-2:0]     pair_idx,
  output logic                     block_done,
  output logic                     sat_seen
);

  localparam int unsigned PtrW  = $clog2(N);
  localparam int unsigned IdxW  = PtrW - 1;
  localparam int unsigned Half  = N / 2;
  localparam int unsigned Shift = IN_FRAC - 4;

  localparam logic signed [IN_W:0] SatMax = (IN_W+1)'(2047);
  localparam logic signed [IN_W:0] SatMin = (IN_W+1)'(-2048);
`ifdef LLR_ROUND_EN
  localparam logic signed [IN_W:0] RndTerm = (Shift > 0) ? (IN_W+1)'(1 << (Shift - 1)) : '0;
`endif

  typedef enum logic [1:0] {StLoad, StIssue, StDone} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IdxW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              sat_q, sat_d;
  logic              wr_en;
  logic [11:0]       mem_q [N];
  logic [11:0]       hold_a_q, hold_b_q;
  logic [IdxW-1:0]   hold_idx_q;

  logic signed [IN_W:0] ext, sum, shifted;
  logic [11:0]          conv;
  logic                 conv_sat;
  logic [11:0]          rd_a, rd_b;

  // One extra bit of headroom so the rounding add can never wrap.
  always_comb begin
    ext = {in_llr[IN_W-1], in_llr};
`ifdef LLR_ROUND_EN
    sum = ext + RndTerm;
`else
    sum = ext;
`endif
    shifted  = sum >>> Shift;
    conv_sat = 1'b0;
    if (shifted > SatMax) begin
      conv     = 12'h7FF;
      conv_sat = 1'b1;
    end else if (shifted < SatMin) begin
      conv     = 12'h800;
      conv_sat = 1'b1;
    end else begin
      conv = shifted[11:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sat_d    = sat_q;
    wr_en    = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (conv_sat) sat_d = 1'b1;
          if (wr_ptr_q == PtrW'(N - 1)) begin
            wr_ptr_d = '0;
            state_d  = StIssue;
          end else begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
          end
        end
      end
      StIssue: begin
        if (pair_ready) begin
          if (rd_ptr_q == IdxW'(Half - 1)) begin
            rd_ptr_d = '0;
            state_d  = StDone;
          end else begin
            rd_ptr_d = rd_ptr_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        sat_d   = 1'b0;
        state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  assign rd_a = mem_q[{1'b0, rd_ptr_q}];
  assign rd_b = mem_q[{1'b1, rd_ptr_q}];

  always_comb begin
    in_ready   = (state_q == StLoad);
    pair_valid = (state_q == StIssue);
    block_done = (state_q == StDone);
    sat_seen   = sat_q;
    // Outside ISSUE the pair outputs freeze on whatever was last presented.
    if (state_q == StIssue) begin
      llr_a    = rd_a;
      llr_b    = rd_b;
      pair_idx = rd_ptr_q;
    end else begin
      llr_a    = hold_a_q;
      llr_b    = hold_b_q;
      pair_idx = hold_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sat_q      <= 1'b0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      hold_idx_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sat_q    <= sat_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= conv;
      end
      if (state_q == StIssue) begin
        hold_a_q   <= rd_a;
        hold_b_q   <= rd_b;
        hold_idx_q <= rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_llr_pair_feeder.sv
// Scoreboard bench for llr_pair_feeder: accepted words feed a reference model, expected pairs
// are queued per block and popped on each pair handshake.
module tb_llr_pair_feeder;

  localparam int N       = 8;
  localparam int IN_W    = 16;
  localparam int IN_FRAC = 6;
  localparam int IdxW    = $clog2(N) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_llr;
  logic              pair_valid;
  logic              pair_ready;
  logic [11:0]       llr_a;
  logic [11:0]       llr_b;
  logic [IdxW-1:0]   pair_idx;
  logic              block_done;
  logic              sat_seen;

  llr_pair_feeder #(.N(N), .IN_W(IN_W), .IN_FRAC(IN_FRAC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_llr     (in_llr),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .llr_a      (llr_a),
    .llr_b      (llr_b),
    .pair_idx   (pair_idx),
    .block_done (block_done),
    .sat_seen   (sat_seen)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] mdl_conv(input logic [15:0] v, output bit s);
    int t;
    t = int'($signed(v));
`ifdef LLR_ROUND_EN
    if (IN_FRAC > 4) t = t + (1 << (IN_FRAC - 5));
`endif
    t = t >>> (IN_FRAC - 4);
    s = 1'b0;
    if (t > 2047) begin
      s = 1'b1;
      return 12'h7FF;
    end
    if (t < -2048) begin
      s = 1'b1;
      return 12'h800;
    end
    return 12'(t);
  endfunction

  // Scoreboard state
  logic [IdxW+23:0] exp_q[$];
  bit               sat_exp_q[$];
  logic [11:0]      mdl_buf [N];
  int               mdl_n    = 0;
  bit               mdl_sat  = 0;
  int               acc_cnt  = 0;
  int               done_cnt = 0;
  bit               prev_hs_last = 0;
  bit               prev_done    = 0;
  bit               stall_prev   = 0;
  logic [11:0]      sv_a, sv_b;
  logic [IdxW-1:0]  sv_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_n        = 0;
      mdl_sat      = 0;
      acc_cnt      = 0;
      prev_hs_last = 0;
      prev_done    = 0;
      stall_prev   = 0;
    end else begin
      if (block_done || prev_hs_last) check("block_done", block_done, prev_hs_last);
      if (block_done) begin
        check("done_pv", pair_valid, 0);
        check("done_acc", acc_cnt, N);
        acc_cnt = 0;
        done_cnt++;
        if (sat_exp_q.size() > 0) check("done_sat", sat_seen, sat_exp_q.pop_front());
      end
      if (prev_done) begin
        check("post_sat", sat_seen, 0);
        check("post_rdy", in_ready, 1);
      end
      if (pair_valid || block_done) check("busy_rdy", in_ready, 0);
      if (stall_prev && pair_valid) begin
        check("hold_a", llr_a, sv_a);
        check("hold_b", llr_b, sv_b);
        check("hold_idx", pair_idx, sv_idx);
      end
      if (in_valid && in_ready) begin
        bit s;
        mdl_buf[mdl_n] = mdl_conv(in_llr, s);
        mdl_sat = mdl_sat | s;
        mdl_n++;
        acc_cnt++;
        if (mdl_n == N) begin
          for (int i = 0; i < N / 2; i++)
            exp_q.push_back({IdxW'(i), mdl_buf[i], mdl_buf[i + N / 2]});
          sat_exp_q.push_back(mdl_sat);
          mdl_n   = 0;
          mdl_sat = 0;
        end
      end
      if (pair_valid && pair_ready) begin
        if (exp_q.size() == 0) begin
          check("pair_unexpected", pair_valid, 0);
        end else begin
          logic [IdxW+23:0] e;
          e = exp_q.pop_front();
          check("pair_idx", pair_idx, e[IdxW+23:24]);
          check("pair_a", llr_a, e[23:12]);
          check("pair_b", llr_b, e[11:0]);
        end
      end
      prev_hs_last = pair_valid && pair_ready && (pair_idx == IdxW'(N / 2 - 1));
      prev_done    = block_done;
      stall_prev   = pair_valid && !pair_ready;
      sv_a   = llr_a;
      sv_b   = llr_b;
      sv_idx = pair_idx;
    end
  end

  // Present a word and wait until the DUT will take it on the coming edge.
  task automatic send(input logic [15:0] v);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_llr   = v;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    check("send_timeout", in_ready, 1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (block_done) return;
    end
    check("done_timeout", block_done, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, in_ready, 1);
    check({tag, "_pv"}, pair_valid, 0);
    check({tag, "_a"}, llr_a, 0);
    check({tag, "_b"}, llr_b, 0);
    check({tag, "_idx"}, pair_idx, 0);
    check({tag, "_done"}, block_done, 0);
    check({tag, "_sat"}, sat_seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s6_start;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_llr     = '0;
    pair_ready = 1'b0;
    #2;
    check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: ramp block, downstream always ready
    pair_ready = 1'b1;
    for (int k = 0; k < N; k++) send(16'(k * 16'h0040));
    idle();
    for (int i = 0; i < N / 2; i++) begin
      @(negedge clk);
      check("s1_pv", pair_valid, 1);
      check("s1_idx", pair_idx, i);
    end
    @(negedge clk);
    check("s1_done", block_done, 1);

    // 2: saturation both ways, sticky until DONE
    @(posedge clk);
    #1 pair_ready = 1'b0;
    send(16'h7FFF);
    send(16'h8000);
    for (int k = 0; k < N - 2; k++) send(16'h0000);
    idle();
    @(negedge clk);
    check("s2_sat_issue", sat_seen, 1);
    @(posedge clk);
    #1 pair_ready = 1'b1;
    wait_done();
    check("s2_sat_done", sat_seen, 1);
    @(negedge clk);
    check("s2_sat_after", sat_seen, 0);

    // 3: floor vs rounding of small values
    send(16'hFFFF);
    send(16'h0002);
    for (int k = 0; k < N - 2; k++) send(16'(k * 3 - 5));
    idle();
    wait_done();

    // 4: backpressure on pair 1 with in_valid held high throughout ISSUE/DONE
    @(posedge clk);
    #1 pair_ready = 1'b0;
    for (int k = 0; k < N; k++) send(16'($urandom));
    @(posedge clk);
    #1 pair_ready = 1'b1;
    in_llr = 16'($urandom);
    @(posedge clk);
    #1 pair_ready = 1'b0;
    in_llr = 16'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("s4_stall_pv", pair_valid, 1);
      check("s4_stall_idx", pair_idx, 1);
      @(posedge clk);
      #1 in_llr = 16'($urandom);
    end
    pair_ready = 1'b1;
    wait_done();
    in_valid = 1'b0;

    // 5: reset after a partial block
    for (int k = 0; k < 5; k++) send(16'(k * 16'h0040 + 16'h0123));
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check_reset_vals("s5");
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("s5_queue", exp_q.size(), 0);
    for (int k = 0; k < N; k++) send(16'(k * 16'h0040));
    idle();
    wait_done();

    // 6: back-to-back blocks, random backpressure
    s6_start = done_cnt;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk);
      #1;
      in_valid   = 1'b1;
      in_llr     = 16'($urandom);
      pair_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    pair_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !pair_valid && !block_done) break;
    end
    check("s6_drain", exp_q.size(), 0);
    check("s6_blocks", (done_cnt - s6_start) >= 4, 1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
